// File: rtl/window_gate_multi.sv
// Multi-channel circular window comparator with debounced, registered gates and edge pulses.
// Optional sticky event/interrupt outputs are built when WINDOW_GATE_IRQ_EN is defined.
module window_gate_multi #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int FILT  = 2,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pos,
  input  logic             pos_valid,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic             cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_commit,
`ifdef WINDOW_GATE_IRQ_EN
  input  logic [CH-1:0]    evt_clr,
  output logic             irq,
  output logic [CH-1:0]    evt,
`endif
  output logic [CH-1:0]    gate,
  output logic [CH-1:0]    gate_rise,
  output logic [CH-1:0]    gate_fall,
  output logic [WIDTH-1:0] pos_q
);

  localparam int CW = 4;

  logic [WIDTH-1:0] sh_open_q  [CH];
  logic [WIDTH-1:0] sh_close_q [CH];
  logic [WIDTH-1:0] sh_open_d  [CH];
  logic [WIDTH-1:0] sh_close_d [CH];
  logic [WIDTH-1:0] act_open_q [CH];
  logic [WIDTH-1:0] act_close_q[CH];
  logic [CW-1:0]    cnt_q      [CH];
  logic [CW-1:0]    cnt_d      [CH];
  logic [CH-1:0]    raw;
  logic [CH-1:0]    gate_q, gate_d;
  logic [CH-1:0]    rise_q, rise_d;
  logic [CH-1:0]    fall_q, fall_d;
  logic [WIDTH-1:0] pos_smp_q;

  // Half-open circular interval [o, c); o == c is empty.
  function automatic logic in_window(input logic [WIDTH-1:0] p,
                                     input logic [WIDTH-1:0] o,
                                     input logic [WIDTH-1:0] c);
    if (o < c)      return (p >= o) && (p < c);
    else if (o > c) return (p >= o) || (p < c);
    else            return 1'b0;
  endfunction

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      raw[i] = in_window(pos, act_open_q[i], act_close_q[i]);
    end
  end

  // Shadow next-state also feeds the commit, so a same-cycle write is captured.
  always_comb begin
    sh_open_d  = sh_open_q;
    sh_close_d = sh_close_q;
    for (int i = 0; i < CH; i++) begin
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        if (cfg_sel) sh_close_d[i] = cfg_data;
        else         sh_open_d[i]  = cfg_data;
      end
    end
  end

  always_comb begin
    gate_d = gate_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    if (pos_valid) begin
      for (int i = 0; i < CH; i++) begin
        if (raw[i] == gate_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(FILT - 1)) begin
          gate_d[i] = raw[i];
          cnt_d[i]  = '0;
          rise_d[i] = raw[i];
          fall_d[i] = ~raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    if (cfg_commit) begin
      for (int i = 0; i < CH; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        sh_open_q[i]   <= '0;
        sh_close_q[i]  <= '0;
        act_open_q[i]  <= '0;
        act_close_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
      gate_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pos_smp_q <= '0;
    end else begin
      sh_open_q  <= sh_open_d;
      sh_close_q <= sh_close_d;
      if (cfg_commit) begin
        act_open_q  <= sh_open_d;
        act_close_q <= sh_close_d;
      end
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      if (pos_valid) pos_smp_q <= pos;
    end
  end

  assign gate      = gate_q;
  assign gate_rise = rise_q;
  assign gate_fall = fall_q;
  assign pos_q     = pos_smp_q;

`ifdef WINDOW_GATE_IRQ_EN
  logic [CH-1:0] evt_q, evt_d;
  logic          irq_q;

  // A pulse arriving with a clear keeps the event set.
  assign evt_d = (evt_q & ~evt_clr) | rise_q | fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= |evt_d;
    end
  end

  assign evt = evt_q;
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_window_gate_multi.sv
// Directed bench for window_gate_multi: instances at FILT=1/2/3 and a CH=3 instance share stimulus.
module tb_window_gate_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pos = '0;
  logic       pos_valid = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic       cfg_sel = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       cfg_commit = 1'b0;
  logic [3:0] evt_clr = '0;

  logic [3:0] gate1, rise1, fall1, gate2, rise2, fall2, gate3, rise3, fall3;
  logic [2:0] gate4, rise4, fall4;
  logic [7:0] posq1, posq2, posq3, posq4;
`ifdef WINDOW_GATE_IRQ_EN
  logic       irq1, irq2, irq3, irq4;
  logic [3:0] evt1, evt2, evt3;
  logic [2:0] evt4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  window_gate_multi #(.WIDTH(8), .CH(4), .FILT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .pos(pos), .pos_valid(pos_valid), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
`ifdef WINDOW_GATE_IRQ_EN
    .evt_clr(evt_clr), .irq(irq1), .evt(evt1),
`endif
    .gate(gate1), .gate_rise(rise1), .gate_fall(fall1), .pos_q(posq1));

  window_gate_multi #(.WIDTH(8), .CH(4), .FILT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .pos(pos), .pos_valid(pos_valid), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
`ifdef WINDOW_GATE_IRQ_EN
    .evt_clr(evt_clr), .irq(irq2), .evt(evt2),
`endif
    .gate(gate2), .gate_rise(rise2), .gate_fall(fall2), .pos_q(posq2));

  window_gate_multi #(.WIDTH(8), .CH(4), .FILT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .pos(pos), .pos_valid(pos_valid), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
`ifdef WINDOW_GATE_IRQ_EN
    .evt_clr(evt_clr), .irq(irq3), .evt(evt3),
`endif
    .gate(gate3), .gate_rise(rise3), .gate_fall(fall3), .pos_q(posq3));

  window_gate_multi #(.WIDTH(8), .CH(3), .FILT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .pos(pos), .pos_valid(pos_valid), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
`ifdef WINDOW_GATE_IRQ_EN
    .evt_clr(evt_clr[2:0]), .irq(irq4), .evt(evt4),
`endif
    .gate(gate4), .gate_rise(rise4), .gate_fall(fall4), .pos_q(posq4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [7:0] p);
    pos = p;
    pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic sel, input logic [7:0] d, input logic com);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d; cfg_commit = com;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] wp [6];
    logic       we [6];
    logic [7:0] dp [6];
    logic       de [6];
    wp = '{8'd199, 8'd200, 8'd255, 8'd0, 8'd49, 8'd50};
    we = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dp = '{8'd15, 8'd15, 8'd5, 8'd15, 8'd15, 8'd15};
    de = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    tick();
    chk("rst_gate", 32'(gate1), 32'h0);
    chk("rst_posq", 32'(posq1), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_pulses", 32'({rise1, fall1}), 32'h0);

    // Non-wrapped window, FILT=1
    wr(2'd0, 1'b0, 8'd10, 1'b0);
    wr(2'd0, 1'b1, 8'd20, 1'b0);
    commit();
    smp(8'd9);  chk("nw_9", 32'(gate1[0]), 32'h0);
    smp(8'd10); chk("nw_10", 32'(gate1[0]), 32'h1);
    chk("nw_rise", 32'(rise1), 32'h1);
    smp(8'd19); chk("nw_19", 32'(gate1[0]), 32'h1);
    chk("nw_rise_clr", 32'(rise1), 32'h0);
    smp(8'd20); chk("nw_20", 32'(gate1[0]), 32'h0);
    chk("nw_fall", 32'(fall1), 32'h1);
    chk("nw_posq", 32'(posq1), 32'd20);
    tick();     chk("nw_fall_clr", 32'(fall1), 32'h0);

    // Wrapped window and empty window, FILT=1
    wr(2'd0, 1'b0, 8'd200, 1'b0);
    wr(2'd0, 1'b1, 8'd50, 1'b1);
    for (int i = 0; i < 6; i++) begin
      smp(wp[i]);
      chk($sformatf("wrap_%0d", wp[i]), 32'(gate1[0]), 32'(we[i]));
    end
    wr(2'd3, 1'b0, 8'd77, 1'b0);
    wr(2'd3, 1'b1, 8'd77, 1'b1);
    smp(8'd77); chk("empty_77", 32'(gate1), 32'h0);

    // Debounce, FILT=3, idle cycles between samples
    do_reset();
    wr(2'd0, 1'b0, 8'd10, 1'b0);
    wr(2'd0, 1'b1, 8'd20, 1'b1);
    for (int i = 0; i < 6; i++) begin
      smp(dp[i]);
      chk($sformatf("deb_%0d", i), 32'(gate3[0]), 32'(de[i]));
      tick();
    end
    smp(8'd15);
    chk("deb_hold", 32'(gate3[0]), 32'h1);

    // Out-of-range channel write on the CH=3 instance
    do_reset();
    wr(2'd3, 1'b1, 8'd200, 1'b1);
    smp(8'd50); chk("badch", 32'(gate4), 32'h0);
    wr(2'd2, 1'b1, 8'd200, 1'b1);
    smp(8'd50); chk("goodch", 32'(gate4), 32'h4);

    // Shadow / commit, FILT=2 on ch1
    wr(2'd1, 1'b1, 8'd100, 1'b1);
    smp(8'd50); chk("sc_a", 32'(gate2[1]), 32'h0);
    smp(8'd50); chk("sc_b", 32'(gate2[1]), 32'h1);
    chk("sc_rise", 32'(rise2[1]), 32'h1);
    wr(2'd1, 1'b1, 8'd30, 1'b0);
    smp(8'd50); chk("sc_shadow", 32'(gate2[1]), 32'h1);
    pos = 8'd50; pos_valid = 1'b1; cfg_commit = 1'b1;
    tick();
    pos_valid = 1'b0; cfg_commit = 1'b0;
    chk("sc_commit_old", 32'(gate2[1]), 32'h1);
    smp(8'd50); chk("sc_new1", 32'(gate2[1]), 32'h1);
    smp(8'd50); chk("sc_new2", 32'(gate2[1]), 32'h0);
    chk("sc_fall", 32'(fall2[1]), 32'h1);
    wr(2'd1, 1'b1, 8'd100, 1'b1);
    smp(8'd50); chk("sc_wecom1", 32'(gate2[1]), 32'h0);
    smp(8'd50); chk("sc_wecom2", 32'(gate2[1]), 32'h1);
    smp(8'd150); chk("sc_cnt1", 32'(gate2[1]), 32'h1);
    commit();
    smp(8'd150); chk("sc_cntclr", 32'(gate2[1]), 32'h1);
    smp(8'd150); chk("sc_cnt2", 32'(gate2[1]), 32'h0);

    // Async reset mid-filter, FILT=3
    do_reset();
    wr(2'd0, 1'b0, 8'd0, 1'b0);
    wr(2'd0, 1'b1, 8'd100, 1'b0);
    wr(2'd1, 1'b0, 8'd40, 1'b0);
    wr(2'd1, 1'b1, 8'd60, 1'b0);
    wr(2'd3, 1'b0, 8'd200, 1'b0);
    wr(2'd3, 1'b1, 8'd60, 1'b1);
    smp(8'd50);
    smp(8'd50); chk("ar_pre", 32'(gate3), 32'h0);
    smp(8'd50); chk("ar_set", 32'(gate3), 32'hB);
    smp(8'd150); chk("ar_hold", 32'(gate3), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gate", 32'(gate3), 32'h0);
    chk("ar_posq", 32'(posq3), 32'h0);
    chk("ar_pulse", 32'({rise3, fall3}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("ar_post", 32'({gate3, rise3, fall3}), 32'h0);

`ifdef WINDOW_GATE_IRQ_EN
    do_reset();
    wr(2'd2, 1'b0, 8'd10, 1'b0);
    wr(2'd2, 1'b1, 8'd20, 1'b1);
    smp(8'd15); chk("irq_rise", 32'(rise1), 32'h4);
    tick();
    chk("irq_evt", 32'(evt1), 32'h4);
    chk("irq_irq", 32'(irq1), 32'h1);
    smp(8'd25); chk("irq_fall", 32'(fall1), 32'h4);
    evt_clr = 4'b0100;
    tick();
    chk("irq_setwins", 32'(evt1), 32'h4);
    tick();
    evt_clr = 4'b0000;
    chk("irq_clr_evt", 32'(evt1), 32'h0);
    chk("irq_clr_irq", 32'(irq1), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
